// File: rtl/am2909_seq_ctrl.sv
// Next-address control for cascaded Am2909 slices: decodes opcode and test
// condition into S/FE/PUP/RE/ZERO, and owns the loop counter, stack-depth shadow and error flag.
module am2909_seq_ctrl #(
    parameter int CW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          CP,
    input  logic          RST,
    input  logic [3:0]    I,
    input  logic          CCEN,
    input  logic          CC,
    input  logic [CW-1:0] D_CNT,
    output logic [1:0]    S,
    output logic          FE,
    output logic          PUP,
    output logic          RE,
    output logic          ZERO,
    output logic          CNT_ZERO,
    output logic [2:0]    SP,
    output logic          ERR
);

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,
        OP_CJS  = 4'd1,
        OP_JMAP = 4'd2,
        OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,
        OP_CRTN = 4'd5,
        OP_LDCT = 4'd6,
        OP_RPCT = 4'd7,
        OP_RFCT = 4'd8,
        OP_LOOP = 4'd9,
        OP_CONT = 4'd10,
        OP_LDAR = 4'd11,
        OP_JRP  = 4'd12
    } opcode_t;

    localparam logic [1:0] SEL_UPC = 2'b00;
    localparam logic [1:0] SEL_AR  = 2'b01;
    localparam logic [1:0] SEL_STK = 2'b10;
    localparam logic [1:0] SEL_D   = 2'b11;
    localparam logic [2:0] SP_FULL = 3'(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sp_q, sp_d;
    logic          err_q, err_d;

    logic          pass;
    logic          cnt_nz;
    logic [1:0]    s_dec;
    logic          push_req, pop_req;
    logic          ld_cnt, dec_cnt, clr_sp;
    logic          re_dec, zero_dec;
    logic          push_ok, pop_ok, push_err, pop_err;

    assign pass   = CCEN | ~CC;
    assign cnt_nz = (cnt_q != '0);

    always_comb begin
        s_dec    = SEL_UPC;
        push_req = 1'b0;
        pop_req  = 1'b0;
        ld_cnt   = 1'b0;
        dec_cnt  = 1'b0;
        clr_sp   = 1'b0;
        re_dec   = 1'b1;
        zero_dec = 1'b1;
        case (opcode_t'(I))
            OP_JZ: begin
                zero_dec = 1'b0;
                clr_sp   = 1'b1;
            end
            OP_CJS: begin
                if (pass) begin
                    s_dec    = SEL_D;
                    push_req = 1'b1;
                end
            end
            OP_JMAP: s_dec = SEL_D;
            OP_CJP: begin
                if (pass) s_dec = SEL_D;
            end
            OP_PUSH: begin
                push_req = 1'b1;
                ld_cnt   = pass;
            end
            OP_CRTN: begin
                if (pass) begin
                    s_dec   = SEL_STK;
                    pop_req = 1'b1;
                end
            end
            OP_LDCT: ld_cnt = 1'b1;
            OP_RPCT: begin
                if (cnt_nz) begin
                    s_dec   = SEL_D;
                    dec_cnt = 1'b1;
                end
            end
            OP_RFCT: begin
                if (cnt_nz) begin
                    s_dec   = SEL_STK;
                    dec_cnt = 1'b1;
                end else begin
                    pop_req = 1'b1;
                end
            end
            OP_LOOP: begin
                if (pass) pop_req = 1'b1;
                else      s_dec   = SEL_STK;
            end
            OP_LDAR: re_dec = 1'b0;
            OP_JRP:  s_dec  = pass ? SEL_D : SEL_AR;
            default: ;
        endcase
    end

    // The 2909 stack has no overflow detection of its own; refuse the
    // operation here and remember that microcode misbehaved.
    assign push_ok  = push_req && (sp_q != SP_FULL);
    assign push_err = push_req && (sp_q == SP_FULL);
    assign pop_ok   = pop_req  && (sp_q != 3'd0);
    assign pop_err  = pop_req  && (sp_q == 3'd0);

    always_comb begin
        S    = s_dec;
        FE   = ~(push_ok | pop_ok);
        PUP  = push_req;
        RE   = re_dec;
        ZERO = zero_dec;
        if (RST) begin
            S    = SEL_UPC;
            FE   = 1'b1;
            PUP  = 1'b0;
            RE   = 1'b1;
            ZERO = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        sp_d  = sp_q;
        err_d = err_q | push_err | pop_err;
        if (ld_cnt) begin
            cnt_d = D_CNT;
        end else if (dec_cnt) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (clr_sp) begin
            sp_d = 3'd0;
        end else if (push_ok) begin
            sp_d = sp_q + 3'd1;
        end else if (pop_ok) begin
            sp_d = sp_q - 3'd1;
        end
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            cnt_q <= '0;
            sp_q  <= 3'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    assign CNT_ZERO = ~cnt_nz;
    assign SP       = sp_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_am2909_seq_ctrl.sv
// Directed bench for am2909_seq_ctrl: each task drives one scenario and checks
// outputs against hand-computed values.
module tb_am2909_seq_ctrl;

    logic       CP = 1'b0;
    logic       RST;
    logic [3:0] I;
    logic       CCEN;
    logic       CC;
    logic [7:0] D_CNT;
    logic [1:0] S;
    logic       FE, PUP, RE, ZERO, CNT_ZERO, ERR;
    logic [2:0] SP;

    int errors = 0;
    int checks = 0;

    am2909_seq_ctrl #(.CW(8), .DEPTH(4)) dut (
        .CP(CP), .RST(RST), .I(I), .CCEN(CCEN), .CC(CC), .D_CNT(D_CNT),
        .S(S), .FE(FE), .PUP(PUP), .RE(RE), .ZERO(ZERO),
        .CNT_ZERO(CNT_ZERO), .SP(SP), .ERR(ERR)
    );

    always #5 CP = ~CP;

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic ccen, input logic cc,
                         input logic [7:0] d);
        I = op; CCEN = ccen; CC = cc; D_CNT = d;
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(4'd10, 1'b1, 1'b1, 8'd0);
        step();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(4'd4, 1'b1, 1'b0, 8'd5);
        checks++; if (ZERO !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", ZERO); end
        checks++; if ({S, FE, PUP, RE} !== 5'b00101) begin errors++; $display("FAIL reset_outs got=%b exp=00101", {S, FE, PUP, RE}); end
        step();
        RST = 1'b0;
        drive(4'd10, 1'b1, 1'b1, 8'd0);
        checks++; if (SP !== 3'd0) begin errors++; $display("FAIL reset_sp got=%0d exp=0", SP); end
        checks++; if (CNT_ZERO !== 1'b1) begin errors++; $display("FAIL reset_cntz got=%b exp=1", CNT_ZERO); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", ERR); end
        checks++; if (ZERO !== 1'b1) begin errors++; $display("FAIL cont_zero got=%b exp=1", ZERO); end
    endtask

    task automatic test_subroutine();
        do_reset();
        drive(4'd1, 1'b0, 1'b0, 8'd0);
        checks++; if ({S, FE, PUP} !== 4'b1101) begin errors++; $display("FAIL cjs_outs got=%b exp=1101", {S, FE, PUP}); end
        step();
        checks++; if (SP !== 3'd1) begin errors++; $display("FAIL cjs_sp got=%0d exp=1", SP); end
        drive(4'd5, 1'b0, 1'b1, 8'd0);
        checks++; if ({S, FE} !== 3'b001) begin errors++; $display("FAIL crtn_fail_outs got=%b exp=001", {S, FE}); end
        step();
        checks++; if (SP !== 3'd1) begin errors++; $display("FAIL crtn_fail_sp got=%0d exp=1", SP); end
        drive(4'd5, 1'b0, 1'b0, 8'd0);
        checks++; if ({S, FE, PUP} !== 4'b1000) begin errors++; $display("FAIL crtn_outs got=%b exp=1000", {S, FE, PUP}); end
        step();
        checks++; if (SP !== 3'd0) begin errors++; $display("FAIL crtn_sp got=%0d exp=0", SP); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL crtn_err got=%b exp=0", ERR); end
    endtask

    task automatic test_repeat();
        logic [1:0] exp_s [4]  = '{2'b11, 2'b11, 2'b11, 2'b00};
        logic       exp_cz [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        drive(4'd6, 1'b1, 1'b1, 8'd3);
        step();
        checks++; if (CNT_ZERO !== 1'b0) begin errors++; $display("FAIL ldct_cntz got=%b exp=0", CNT_ZERO); end
        for (int k = 0; k < 4; k++) begin
            drive(4'd7, 1'b1, 1'b1, 8'd0);
            checks++; if (S !== exp_s[k]) begin errors++; $display("FAIL rpct_s[%0d] got=%b exp=%b", k, S, exp_s[k]); end
            step();
            checks++; if (CNT_ZERO !== exp_cz[k]) begin errors++; $display("FAIL rpct_cntz[%0d] got=%b exp=%b", k, CNT_ZERO, exp_cz[k]); end
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        drive(4'd6, 1'b1, 1'b1, 8'd5);
        step();
        drive(4'd7, 1'b1, 1'b1, 8'd0);
        step();
        RST = 1'b1;
        drive(4'd7, 1'b1, 1'b1, 8'd0);
        checks++; if ({S, ZERO} !== 3'b000) begin errors++; $display("FAIL abort_rst_outs got=%b exp=000", {S, ZERO}); end
        step();
        RST = 1'b0;
        #1;
        checks++; if (CNT_ZERO !== 1'b1) begin errors++; $display("FAIL abort_cntz got=%b exp=1", CNT_ZERO); end
        checks++; if (S !== 2'b00) begin errors++; $display("FAIL abort_rpct_s got=%b exp=00", S); end
    endtask

    task automatic test_push_load();
        do_reset();
        drive(4'd4, 1'b1, 1'b1, 8'd2);
        step();
        checks++; if (SP !== 3'd1) begin errors++; $display("FAIL pushld_sp got=%0d exp=1", SP); end
        for (int k = 0; k < 3; k++) begin
            drive(4'd7, 1'b1, 1'b1, 8'd0);
            checks++; if (S !== ((k < 2) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL pushld_rpct_s[%0d] got=%b", k, S); end
            step();
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(4'd4, 1'b0, 1'b1, 8'd9);
            checks++; if (FE !== ((k < 4) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL ovf_fe[%0d] got=%b", k, FE); end
            step();
        end
        checks++; if (SP !== 3'd4) begin errors++; $display("FAIL ovf_sp got=%0d exp=4", SP); end
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b exp=1", ERR); end
        checks++; if (CNT_ZERO !== 1'b1) begin errors++; $display("FAIL ovf_noload got=%b exp=1", CNT_ZERO); end
        drive(4'd0, 1'b1, 1'b1, 8'd0);
        checks++; if (ZERO !== 1'b0) begin errors++; $display("FAIL jz_zero got=%b exp=0", ZERO); end
        step();
        checks++; if (SP !== 3'd0) begin errors++; $display("FAIL jz_sp got=%0d exp=0", SP); end
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL jz_err got=%b exp=1", ERR); end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(4'd5, 1'b1, 1'b1, 8'd0);
        checks++; if ({S, FE} !== 3'b101) begin errors++; $display("FAIL unf_outs got=%b exp=101", {S, FE}); end
        step();
        checks++; if (SP !== 3'd0) begin errors++; $display("FAIL unf_sp got=%0d exp=0", SP); end
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL unf_err got=%b exp=1", ERR); end
    endtask

    task automatic test_rfct_loop();
        do_reset();
        drive(4'd1, 1'b1, 1'b1, 8'd0);
        step();
        drive(4'd6, 1'b1, 1'b1, 8'd1);
        step();
        drive(4'd8, 1'b1, 1'b1, 8'd0);
        checks++; if ({S, FE} !== 3'b101) begin errors++; $display("FAIL rfct_nz_outs got=%b exp=101", {S, FE}); end
        step();
        checks++; if (SP !== 3'd1) begin errors++; $display("FAIL rfct_nz_sp got=%0d exp=1", SP); end
        drive(4'd8, 1'b1, 1'b1, 8'd0);
        checks++; if ({S, FE, PUP} !== 4'b0000) begin errors++; $display("FAIL rfct_z_outs got=%b exp=0000", {S, FE, PUP}); end
        step();
        checks++; if (SP !== 3'd0) begin errors++; $display("FAIL rfct_z_sp got=%0d exp=0", SP); end
        drive(4'd4, 1'b0, 1'b1, 8'd0);
        step();
        drive(4'd9, 1'b0, 1'b1, 8'd0);
        checks++; if ({S, FE} !== 3'b101) begin errors++; $display("FAIL loop_fail_outs got=%b exp=101", {S, FE}); end
        step();
        checks++; if (SP !== 3'd1) begin errors++; $display("FAIL loop_fail_sp got=%0d exp=1", SP); end
        drive(4'd9, 1'b1, 1'b1, 8'd0);
        checks++; if ({S, FE, PUP} !== 4'b0000) begin errors++; $display("FAIL loop_pass_outs got=%b exp=0000", {S, FE, PUP}); end
        step();
        checks++; if (SP !== 3'd0) begin errors++; $display("FAIL loop_pass_sp got=%0d exp=0", SP); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL loop_err got=%b exp=0", ERR); end
    endtask

    task automatic test_cond_ar();
        do_reset();
        drive(4'd11, 1'b1, 1'b1, 8'd0);
        checks++; if ({RE, S} !== 3'b000) begin errors++; $display("FAIL ldar_outs got=%b exp=000", {RE, S}); end
        drive(4'd12, 1'b0, 1'b1, 8'd0);
        checks++; if (S !== 2'b01) begin errors++; $display("FAIL jrp_fail_s got=%b exp=01", S); end
        drive(4'd12, 1'b1, 1'b1, 8'd0);
        checks++; if (S !== 2'b11) begin errors++; $display("FAIL jrp_pass_s got=%b exp=11", S); end
        drive(4'd3, 1'b0, 1'b1, 8'd0);
        checks++; if (S !== 2'b00) begin errors++; $display("FAIL cjp_fail_s got=%b exp=00", S); end
        drive(4'd3, 1'b0, 1'b0, 8'd0);
        checks++; if (S !== 2'b11) begin errors++; $display("FAIL cjp_pass_s got=%b exp=11", S); end
        drive(4'd2, 1'b0, 1'b1, 8'd0);
        checks++; if (S !== 2'b11) begin errors++; $display("FAIL jmap_s got=%b exp=11", S); end
        drive(4'd14, 1'b0, 1'b0, 8'd7);
        checks++; if ({S, FE, PUP, RE, ZERO} !== 6'b001011) begin errors++; $display("FAIL op14_outs got=%b exp=001011", {S, FE, PUP, RE, ZERO}); end
        step();
        checks++; if ({SP, CNT_ZERO, ERR} !== 5'b00010) begin errors++; $display("FAIL op14_state got=%b exp=00010", {SP, CNT_ZERO, ERR}); end
    endtask

    initial begin
        RST = 1'b1; I = 4'd0; CCEN = 1'b1; CC = 1'b1; D_CNT = 8'd0;
        #2;
        test_reset();
        test_subroutine();
        test_repeat();
        test_reset_abort();
        test_push_load();
        test_overflow();
        test_underflow();
        test_rfct_loop();
        test_cond_ar();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/am2909_seq_ctrl.md
Name: am2909_seq_ctrl

Overview:
- Next-address control unit that sequences one or more cascaded Am2909 slices. Each cycle it decodes a 4-bit microinstruction opcode and a test condition into the Am2909 select and stack controls: S, FE, PUP, RE and ZERO.
- It owns three pieces of state: the loop/repeat counter, a shadow stack-depth tracker that guards the 2909's 4-word stack, and a sticky error flag.
- Sits between the pipeline register and the 2909 slices; its outputs are sampled by the 2909 on the same CP edge.

Parameters:
- CW, 8, loop counter width in bits.
- DEPTH, 4, stack depth of the attached Am2909 (words).

Ports:
- CP  input  1  clock; all state updates on posedge CP.
- RST  input  1  synchronous reset, active-high.
- I  input  4  microinstruction opcode.
- CCEN  input  1  condition-test enable, active-low.
- CC  input  1  condition input, active-low.
- D_CNT  input  CW  counter load value from the pipeline register.
- S  output  2  2909 source select: 00 µPC, 01 AR, 10 stack, 11 D.
- FE  output  1  2909 stack enable, active-low.
- PUP  output  1  stack direction: 1 push, 0 pop.
- RE  output  1  2909 address-register load enable, active-low.
- ZERO  output  1  2909 output force-zero, active-low.
- CNT_ZERO  output  1  1 when counter == 0.
- SP  output  3  current stack depth, range 0..DEPTH.
- ERR  output  1  sticky stack overflow/underflow flag.

Behaviour:
- PASS = CCEN | ~CC. The test always passes when disabled.
- S, FE, PUP, RE and ZERO are combinational from I, PASS, the counter and SP.
- Counter, SP and ERR update on posedge CP only.
- Defaults for every opcode unless stated otherwise: S=00, FE=1, PUP=0, RE=1, ZERO=1. Counter and SP hold.
- "push" means FE=0, PUP=1, SP+1. "pop" means FE=0, PUP=0, SP-1.
- Opcodes:
  - 0 JZ: ZERO=0; SP<=0.
  - 1 CJS: if PASS, S=11 and push.
  - 2 JMAP: S=11.
  - 3 CJP: if PASS, S=11.
  - 4 PUSH: push; if PASS, counter<=D_CNT.
  - 5 CRTN: if PASS, S=10 and pop.
  - 6 LDCT: counter<=D_CNT.
  - 7 RPCT: if counter!=0, S=11 and counter-1.
  - 8 RFCT: if counter!=0, S=10 and counter-1; else pop.
  - 9 LOOP: if PASS, pop; else S=10.
  - 10 CONT: defaults only.
  - 11 LDAR: RE=0.
  - 12 JRP: S = PASS ? 11 : 01.
  - 13-15: treated as CONT (reserved).
- Counter:
  - Never decrements below 0; no wrap.
  - A load takes the D_CNT value exactly.
- Stack guard:
  - Push with SP==DEPTH: push suppressed (FE=1), SP holds, ERR<=1. S is still as decoded.
  - Pop with SP==0: pop suppressed (FE=1), SP holds, ERR<=1. S is still as decoded (stale TOS).
  - ERR clears only on RST. JZ does not clear ERR.
- Reset:
  - While RST=1, outputs are forced to S=00, FE=1, PUP=0, RE=1, ZERO=0 (2909 Y=0, µPC loads C).
  - On the posedge with RST=1: counter<=0, SP<=0, ERR<=0. This overrides any opcode in flight.
  - A single-cycle RST in the middle of an RPCT loop aborts the loop; the counter reads 0 afterwards.
- CNT_ZERO and SP reflect registered state, so new values are visible after the edge.

Test Plan:
- Reset: RST=1 for 1 edge with I=4, PASS, D_CNT=5 -> ZERO=0 during reset; after the edge SP=0, counter=0, CNT_ZERO=1, ERR=0.
- Subroutine: CJS with CC=0 -> S=11, FE=0, PUP=1, SP 0->1. Then CRTN with CC=1 (fail) -> S=00, FE=1, SP=1. Then CRTN with CC=0 -> S=10, FE=0, PUP=0, SP 1->0.
- Repeat: LDCT with D_CNT=3, then RPCT for 4 cycles -> S=11,11,11,00, counter 3->2->1->0->0, CNT_ZERO=1 at cycle 4.
- Overflow: 5 consecutive PUSH with CCEN=0, CC=1 -> FE=0 on the first 4, FE=1 on the 5th; SP=4; ERR=1 after the 5th edge. ERR survives a following JZ (SP->0).
- Underflow: from reset, CRTN with PASS -> S=10, FE=1, SP=0, ERR=1.
- Conditional/AR: LDAR -> RE=0, S=00. JRP with CC=1, CCEN=0 -> S=01. JRP with CCEN=1 -> S=11. I=14 -> identical to CONT.
